// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with a per-register busy scoreboard for the pipelined core.
//   Two combinational read ports with same-cycle write forwarding, one
//   synchronous write port, and RAW-hazard stall generation for decode.
//   Optional hardwired-zero r0 (ZERO_R0=1).
// Ports
//   clock, reset              rising-edge clock, async active-low reset
//   rd_addr1/2, rd_use1/2     read indices and "operand consumed" qualifiers
//   rd_data1/2, stall         read data (comb) and RAW-hazard stall (comb)
//   claim_en, claim_addr      issuing instruction marks its destination busy
//   wr_en, wr_addr, wr_data   writeback: stores data and retires busy bit
//   flush                     clears every busy bit, data untouched
//   busy_vec, busy_count      registered busy bits and their popcount
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_R0  = 0,
  parameter int CNT_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  input  logic                rd_use1,
  input  logic                rd_use2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                stall,
  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_addr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    busy_count
);

  localparam bit Z0 = (ZERO_R0 != 0);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [CNT_W-1:0]                count_q, count_d;

  // r0 is read-only when hardwired to zero; gate writes/claims there.
  logic wr_ok, claim_ok;
  assign wr_ok    = wr_en    && !(Z0 && wr_addr    == '0);
  assign claim_ok = claim_en && !(Z0 && claim_addr == '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr] = wr_data;
  end

  // Priority: flush > claim > write-retire > hold. Claim beats a same-cycle
  // write so a new producer issued on the retire cycle keeps the reg busy.
  always_comb begin
    busy_d  = busy_q;
    count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (flush)                                       busy_d[i] = 1'b0;
      else if (claim_ok && claim_addr == ADDR_W'(i))   busy_d[i] = 1'b1;
      else if (wr_ok && wr_addr == ADDR_W'(i))         busy_d[i] = 1'b0;
      count_d = count_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q  <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Read ports: forwarding from the write port, and a retiring write clears
  // the hazard in the same cycle. Outputs forced quiet while reset is low.
  logic [1:0][ADDR_W-1:0] rd_addr_a;
  logic [1:0]             rd_use_a;
  logic [1:0][DATA_W-1:0] rd_data_a;

  assign rd_addr_a = {rd_addr2, rd_addr1};
  assign rd_use_a  = {rd_use2, rd_use1};

  always_comb begin
    logic hit, zero, pend;
    hit       = 1'b0;
    zero      = 1'b0;
    pend      = 1'b0;
    stall     = 1'b0;
    rd_data_a = '0;
    for (int p = 0; p < 2; p++) begin
      hit  = wr_ok && wr_addr == rd_addr_a[p];
      zero = Z0 && rd_addr_a[p] == '0;
      rd_data_a[p] = hit ? wr_data : regs_q[rd_addr_a[p]];
      pend = busy_q[rd_addr_a[p]] && !hit;
      if (zero || !reset) begin
        rd_data_a[p] = '0;
        pend         = 1'b0;
      end
      stall = stall || (rd_use_a[p] && pend);
    end
  end

  assign rd_data1   = rd_data_a[0];
  assign rd_data2   = rd_data_a[1];
  assign busy_vec   = busy_q;
  assign busy_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  rd_addr1 = '0, rd_addr2 = '0, claim_addr = '0, wr_addr = '0;
  logic        rd_use1 = 1'b0, rd_use2 = 1'b0, claim_en = 1'b0, wr_en = 1'b0, flush = 1'b0;
  logic [15:0] wr_data = '0;

  logic [15:0] rd1, rd2, zrd1, zrd2;
  logic        stl, zstl;
  logic [7:0]  bv, zbv;
  logic [3:0]  bc, zbc;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  regfile_scoreboard #(.ZERO_R0(0)) u_dut (
    .clock(clock), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_use1(rd_use1), .rd_use2(rd_use2),
    .rd_data1(rd1), .rd_data2(rd2), .stall(stl),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush),
    .busy_vec(bv), .busy_count(bc)
  );

  regfile_scoreboard #(.ZERO_R0(1)) u_dz (
    .clock(clock), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_use1(rd_use1), .rd_use2(rd_use2),
    .rd_data1(zrd1), .rd_data2(zrd2), .stall(zstl),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush),
    .busy_vec(zbv), .busy_count(zbc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // advance one clock; inputs change and checks happen 1ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_rd1", 32'(rd1), 32'h0);
    chk("rst_bv", 32'(bv), 32'h0);
    chk("rst_bc", 32'(bc), 32'h0);
    chk("rst_stall", 32'(stl), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // write r5 with same-cycle bypass, then from storage
    wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF; rd_addr1 = 5;
    #1 chk("byp_r5", 32'(rd1), 32'hBEEF);
    tick();
    wr_en = 0;
    #1 chk("stor_r5", 32'(rd1), 32'hBEEF);

    // claim r2, stall until writeback, retire clears hazard same cycle
    claim_en = 1; claim_addr = 2;
    tick();
    claim_en = 0; rd_addr2 = 2; rd_use2 = 1;
    #1 chk("c3_stall1", 32'(stl), 32'h1);
    chk("c3_bc1", 32'(bc), 32'h1);
    tick();
    chk("c3_stall2", 32'(stl), 32'h1);
    tick();
    wr_en = 1; wr_addr = 2; wr_data = 16'h0042;
    #1 chk("c3_retire_stall", 32'(stl), 32'h0);
    chk("c3_retire_rd2", 32'(rd2), 32'h0042);
    tick();
    wr_en = 0;
    #1 chk("c4_bv2", 32'(bv[2]), 32'h0);
    chk("c4_bc", 32'(bc), 32'h0);
    rd_use2 = 0;

    // same-cycle claim + write to r4: claim wins
    claim_en = 1; claim_addr = 4; wr_en = 1; wr_addr = 4; wr_data = 16'h0007;
    tick();
    claim_en = 0; wr_en = 0; rd_addr1 = 4; rd_use1 = 0;
    #1 chk("r4_data", 32'(rd1), 32'h0007);
    chk("r4_busy", 32'(bv[4]), 32'h1);
    chk("r4_nouse_stall", 32'(stl), 32'h0);
    rd_use1 = 1;
    #1 chk("r4_use_stall", 32'(stl), 32'h1);
    rd_use1 = 0;

    // claims on r1, r6, r7 then flush together with claim r3
    claim_en = 1; claim_addr = 1; tick();
    claim_addr = 6; tick();
    claim_addr = 7; tick();
    claim_en = 0;
    #1 chk("pre_flush_bv", 32'(bv), 32'hD2);
    chk("pre_flush_bc", 32'(bc), 32'h4);
    claim_en = 1; claim_addr = 3; flush = 1;
    tick();
    claim_en = 0; flush = 0; rd_addr1 = 5; rd_addr2 = 4;
    #1 chk("flush_bv", 32'(bv), 32'h0);
    chk("flush_bc", 32'(bc), 32'h0);
    chk("flush_r5", 32'(rd1), 32'hBEEF);
    chk("flush_r4", 32'(rd2), 32'h0007);

    // reset mid-run with r3=0x1234 busy, plus a write to r6 held through reset
    claim_en = 1; claim_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 16'h1234;
    tick();
    claim_en = 0; wr_en = 0; rd_addr1 = 3; rd_use1 = 1;
    #1 chk("pre_rst_r3", 32'(rd1), 32'h1234);
    chk("pre_rst_stall", 32'(stl), 32'h1);
    chk("pre_rst_bv", 32'(bv), 32'h08);
    wr_en = 1; wr_addr = 6; wr_data = 16'h5555; rd_addr2 = 6;
    reset = 0;
    #1 chk("mid_rst_rd1", 32'(rd1), 32'h0);
    chk("mid_rst_rd2", 32'(rd2), 32'h0);
    chk("mid_rst_bv", 32'(bv), 32'h0);
    chk("mid_rst_bc", 32'(bc), 32'h0);
    chk("mid_rst_stall", 32'(stl), 32'h0);
    tick();
    wr_en = 0;
    #1 reset = 1;
    #1 chk("post_rst_r3", 32'(rd1), 32'h0);
    chk("post_rst_r6", 32'(rd2), 32'h0);
    chk("post_rst_stall", 32'(stl), 32'h0);
    rd_use1 = 0;
    tick();

    // hardwired r0: writes/claims ignored in u_dz, live in u_dut
    wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF; claim_en = 1; claim_addr = 0;
    rd_addr1 = 0; rd_use1 = 1;
    #1 chk("z0_byp", 32'(zrd1), 32'h0);
    chk("nz0_byp", 32'(rd1), 32'hFFFF);
    tick();
    wr_en = 0; claim_en = 0;
    #1 chk("z0_rd", 32'(zrd1), 32'h0);
    chk("z0_busy", 32'(zbv[0]), 32'h0);
    chk("z0_bc", 32'(zbc), 32'h0);
    chk("z0_stall", 32'(zstl), 32'h0);
    chk("nz0_rd", 32'(rd1), 32'hFFFF);
    chk("nz0_busy", 32'(bv[0]), 32'h1);
    chk("nz0_stall", 32'(stl), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
